// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/grant bundle between the bus masters and the round-robin arbiter
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 6,
    parameter int N_SLAVES  = 6,
    parameter int SLV_W     = 3
);
    logic [N_MASTERS-1:0]       req;
    logic [N_MASTERS*SLV_W-1:0] tgt;
    logic [N_SLAVES-1:0]        slave_busy;
    logic [N_MASTERS-1:0]       grant;
    logic [2:0]                 owner_id;
    logic                       utilization;
    logic [N_MASTERS-1:0]       requests;
    logic [15:0]                util_count;
    logic                       util_valid;
    logic                       timeout_pulse;
    modport master (
        output req, tgt, slave_busy,
        input  grant, owner_id, utilization, requests, util_count, util_valid, timeout_pulse
    );
    modport slave (
        input  req, tgt, slave_busy,
        output grant, owner_id, utilization, requests, util_count, util_valid, timeout_pulse
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus ownership with turnaround and windowed utilization count.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT ownership cycles.
module bus_arbiter_rr #(
    parameter int N_MASTERS = 6,
    parameter int N_SLAVES  = 6,
    parameter int SLV_W     = 3,
    parameter int WINDOW    = 1024,
    parameter int TIMEOUT   = 4096
) (
    input logic             clk,
    input logic             rst,
    bus_arbiter_rr_if.slave bus
);
    localparam int WW = $clog2(WINDOW);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    state_t r_state, w_next;
    logic [N_MASTERS-1:0] r_grant, w_grant, r_req, w_elig, w_mask;
    logic [2:0] r_owner, w_owner, r_last, w_last, w_hi, w_lo, w_sel;
    logic w_hi_f, w_lo_f, w_to_hit, w_win_end;
    logic [2**SLV_W-1:0] w_busy_x;
    logic [WW-1:0] r_win;
    logic [15:0] r_busy, r_util_cnt, w_busy_sum;
    logic r_util_valid;
    // unpopulated slave slots read as busy, so out-of-range targets are never eligible
    always_comb begin
        w_busy_x = '1;
        w_busy_x[N_SLAVES-1:0] = bus.slave_busy;
        w_elig = '0;
        w_hi = '0;
        w_lo = '0;
        w_hi_f = 1'b0;
        w_lo_f = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            w_elig[i] = bus.req[i] & ~w_busy_x[bus.tgt[i*SLV_W +: SLV_W]] & ~w_mask[i];
            if (w_elig[i] && i > int'(r_last)) begin
                w_hi_f = 1'b1;
                w_hi = 3'(i);
            end
            if (w_elig[i] && i <= int'(r_last)) begin
                w_lo_f = 1'b1;
                w_lo = 3'(i);
            end
        end
        w_sel = w_hi_f ? w_hi : w_lo;
    end
    always_comb begin
        w_next = r_state;
        w_grant = r_grant;
        w_owner = r_owner;
        w_last = r_last;
        if (r_state == IDLE && (w_hi_f || w_lo_f)) begin
            w_next = OWN;
            w_grant = N_MASTERS'(1) << w_sel;
            w_owner = w_sel;
            w_last = w_sel;
        end else if (r_state == OWN && (!bus.req[r_last] || w_to_hit)) begin
            w_next = TURN;
            w_grant = '0;
            w_owner = '0;
        end else if (r_state == TURN) begin
            w_next = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    assign w_win_end = r_win == WW'(WINDOW - 1);
    assign w_busy_sum = (r_busy == 16'hFFFF) ? r_busy : r_busy + 16'(|r_grant);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_owner <= '0;
            r_last <= 3'(N_MASTERS - 1);
            r_req <= '0;
            r_win <= '0;
            r_busy <= '0;
            r_util_cnt <= '0;
            r_util_valid <= 1'b0;
        end else begin
            r_grant <= w_grant;
            r_owner <= w_owner;
            r_last <= w_last;
            r_req <= bus.req;
            r_win <= w_win_end ? '0 : r_win + 1'b1;
            r_busy <= w_win_end ? '0 : w_busy_sum;
            r_util_valid <= w_win_end;
            if (w_win_end) r_util_cnt <= w_busy_sum;
        end
    end
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] r_ocnt;
    logic [N_MASTERS-1:0] r_mask;
    logic r_to, w_to;
    assign w_to_hit = r_state == OWN && r_ocnt == TW'(TIMEOUT - 1);
    assign w_to = w_to_hit & bus.req[r_last];
    assign w_mask = r_mask;
    assign bus.timeout_pulse = r_to;
    // a timed-out master stays masked until it is seen with req low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocnt <= '0;
            r_mask <= '0;
            r_to <= 1'b0;
        end else begin
            r_ocnt <= (r_state == OWN) ? r_ocnt + 1'b1 : '0;
            r_mask <= (r_mask & bus.req) | (w_to ? N_MASTERS'(1) << r_last : '0);
            r_to <= w_to;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign w_mask = '0;
    assign bus.timeout_pulse = 1'b0;
`endif
    assign bus.grant = r_grant;
    assign bus.owner_id = r_owner;
    assign bus.utilization = |r_grant;
    assign bus.requests = r_req;
    assign bus.util_count = r_util_cnt;
    assign bus.util_valid = r_util_valid;
endmodule
